sliding_window_buffer: RTL and testbench



---
 rtl/sliding_window_buffer.sv | 131 +++++++++++++
 tb/tb_sliding_window_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_buffer.sv
// K x K sliding-window generator for raster pixel streams with self-tracked position.
// Define WINDOW_BORDER_MASK_EN to zero-pad left/top border taps and pulse valid on every beat.
module sliding_window_buffer #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned KSIZE       = 3,
    parameter int unsigned FRAME_WIDTH = 640,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                en,
    input  logic                                hsync,
    input  logic                                vsync,
    input  logic [DATA_WIDTH-1:0]               data_in,
    output logic [KSIZE*KSIZE*DATA_WIDTH-1:0]   window_out,
    output logic                                valid,
    output logic [15:0]                         x_out,
    output logic [15:0]                         y_out
);

    localparam int unsigned POS_W    = 16;
    localparam int unsigned KM1      = KSIZE - 1;
    localparam int unsigned WIN_W    = KSIZE * KSIZE * DATA_WIDTH;
    localparam int unsigned LAST_COL = FRAME_WIDTH - 1;

    logic [POS_W-1:0]      col_q, row_q, col_d, row_d;
    logic [POS_W-1:0]      px_x, px_y;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rd_col  [KM1];
    logic [DATA_WIDTH-1:0] new_col [KSIZE];
    logic [WIN_W-1:0]      win_q, win_d, win_out_d;
    logic                  valid_d;

    // Position of the incoming pixel and the counter values that follow it
    always_comb begin
        px_x  = col_q;
        px_y  = row_q;
        col_d = col_q;
        row_d = row_q;
        if (vsync) begin
            px_x  = '0;
            px_y  = '0;
            col_d = POS_W'(1);
            row_d = '0;
        end else if (hsync) begin
            px_x  = '0;
            px_y  = (col_q != '0) ? row_q + POS_W'(1) : row_q;
            col_d = POS_W'(1);
            row_d = px_y;
        end else if (col_q == POS_W'(LAST_COL)) begin
            col_d = '0;
            row_d = row_q + POS_W'(1);
        end else begin
            col_d = col_q + POS_W'(1);
        end
    end

    assign addr = ADDR_WIDTH'(px_x);

    // Cascaded line memories: each one feeds the next, read-before-write per column
    for (genvar i = 0; i < KM1; i++) begin : g_line
        logic [DATA_WIDTH-1:0] mem [FRAME_WIDTH];
        assign rd_col[i] = mem[addr];
        if (i == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (en) mem[addr] <= data_in;
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (en) mem[addr] <= rd_col[i-1];
            end
        end
    end

    // Column vector entering the window, oldest row first
    for (genvar r = 0; r < KM1; r++) begin : g_col
        assign new_col[r] = rd_col[KM1-1-r];
    end
    assign new_col[KM1] = data_in;

    // Shift each window row left by one; border taps are optionally zeroed on output
    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_tap
            localparam int unsigned T = r * KSIZE + c;
            if (c == KM1) begin : g_in
                assign win_d[T*DATA_WIDTH +: DATA_WIDTH] = new_col[r];
            end else begin : g_sh
                assign win_d[T*DATA_WIDTH +: DATA_WIDTH] = win_q[(T+1)*DATA_WIDTH +: DATA_WIDTH];
            end
`ifdef WINDOW_BORDER_MASK_EN
            logic keep;
            assign keep = ({1'b0, px_x} + 17'(c) >= 17'(KM1)) &&
                          ({1'b0, px_y} + 17'(r) >= 17'(KM1));
            assign win_out_d[T*DATA_WIDTH +: DATA_WIDTH] =
                keep ? win_d[T*DATA_WIDTH +: DATA_WIDTH] : '0;
`else
            assign win_out_d[T*DATA_WIDTH +: DATA_WIDTH] = win_d[T*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end

`ifdef WINDOW_BORDER_MASK_EN
    assign valid_d = 1'b1;
`else
    assign valid_d = (px_x >= POS_W'(KM1)) && (px_y >= POS_W'(KM1));
`endif

    // Registered position, window and output state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            win_q      <= '0;
            window_out <= '0;
            valid      <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
        end else begin
            valid <= en & valid_d;
            if (en) begin
                col_q      <= col_d;
                row_q      <= row_d;
                win_q      <= win_d;
                window_out <= win_out_d;
                x_out      <= px_x;
                y_out      <= px_y;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Randomized and directed bench for sliding_window_buffer (K=3/FW=8 and K=5/FW=16 instances).
module tb_sliding_window_buffer;

    localparam int unsigned MAXW = 250;
`ifdef WINDOW_BORDER_MASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [9:0]  din = '0;
    logic [71:0]  win_a;
    logic [249:0] win_b;
    logic        valid_a, valid_b;
    logic [15:0] xa, ya, xb, yb;

    always #5 clk = ~clk;

    sliding_window_buffer #(.DATA_WIDTH(8), .KSIZE(3), .FRAME_WIDTH(8), .ADDR_WIDTH(3)) u_a (
        .clk(clk), .reset_n(reset_n), .en(en_a), .hsync(hsync), .vsync(vsync),
        .data_in(din[7:0]), .window_out(win_a), .valid(valid_a), .x_out(xa), .y_out(ya));

    sliding_window_buffer #(.DATA_WIDTH(10), .KSIZE(5), .FRAME_WIDTH(16), .ADDR_WIDTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .en(en_b), .hsync(hsync), .vsync(vsync),
        .data_in(din), .window_out(win_b), .valid(valid_b), .x_out(xb), .y_out(yb));

    int checks = 0, errors = 0;
    int sel = 0, K = 3, FW = 8, DW = 8;
    int col = 0, row = 0;
    int hist [16][$];
    int wv [7][7];
    bit wk [7][7];
    int exp_x = 0, exp_y = 0;
    bit exp_v = 1'b0;
    int vcount = 0;
    bit fv_seen = 1'b0;
    logic [15:0] fx, fy;
    logic [MAXW-1:0] fw;

    // Reference: per-column pixel history gives the rows above; window keeps the last K columns
    task automatic model_beat(input bit hs, input bit vs, input int d);
        int px, py, sz, n;
        int cv [7];
        bit ck [7];
        if (vs) begin
            px = 0; py = 0; col = 1; row = 0;
        end else if (hs) begin
            px = 0; py = (col != 0) ? ((row + 1) & 65535) : row; row = py; col = 1;
        end else begin
            px = col; py = row;
            if (col == FW - 1) begin col = 0; row = (row + 1) & 65535; end
            else col = col + 1;
        end
        sz = hist[px].size();
        for (int r = 0; r < K - 1; r++) begin
            n = K - 1 - r;
            ck[r] = (sz >= n);
            cv[r] = (sz >= n) ? hist[px][sz - n] : 0;
        end
        cv[K-1] = d; ck[K-1] = 1'b1;
        hist[px].push_back(d);
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                wv[r][c] = wv[r][c+1]; wk[r][c] = wk[r][c+1];
            end
            wv[r][K-1] = cv[r]; wk[r][K-1] = ck[r];
        end
        exp_x = px; exp_y = py;
        exp_v = MASK ? 1'b1 : (px >= K - 1 && py >= K - 1);
    endtask

    task automatic model_reset();
        col = 0; row = 0; exp_x = 0; exp_y = 0; exp_v = 1'b0;
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) begin wv[r][c] = 0; wk[r][c] = 1'b1; end
    endtask

    task automatic check_all(input string tag);
        logic [MAXW-1:0] ow, ew, cw;
        logic [15:0] ox, oy;
        logic ov;
        int base, val;
        bit kn;
        if (sel == 0) begin ow = MAXW'(win_a); ox = xa; oy = ya; ov = valid_a; end
        else begin ow = win_b; ox = xb; oy = yb; ov = valid_b; end
        ew = '0; cw = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                base = (r * K + c) * DW;
                if (MASK && (exp_x < K - 1 - c || exp_y < K - 1 - r)) begin val = 0; kn = 1'b1; end
                else begin val = wv[r][c]; kn = wk[r][c]; end
                for (int b = 0; b < DW; b++) begin ew[base+b] = val[b]; cw[base+b] = kn; end
            end
        end
        checks++;
        assert (ov === exp_v) else begin
            errors++; $error("FAIL %s valid: got %0b want %0b", tag, ov, exp_v);
        end
        checks++;
        assert (ox === 16'(exp_x)) else begin
            errors++; $error("FAIL %s x_out: got %0d want %0d", tag, ox, exp_x);
        end
        checks++;
        assert (oy === 16'(exp_y)) else begin
            errors++; $error("FAIL %s y_out: got %0d want %0d", tag, oy, exp_y);
        end
        checks++;
        assert ((ow & cw) === (ew & cw)) else begin
            errors++; $error("FAIL %s window: got %h want %h", tag, ow & cw, ew & cw);
        end
        if (ov === 1'b1) begin
            vcount++;
            if (!fv_seen) begin fv_seen = 1'b1; fx = ox; fy = oy; fw = ow; end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next one
    task automatic step(input bit e, input bit hs, input bit vs, input int d, input string tag);
        int dm;
        dm = d & ((1 << DW) - 1);
        en_a = (sel == 0) && e; en_b = (sel == 1) && e;
        hsync = hs; vsync = vs; din = 10'(dm);
        @(posedge clk);
        #1;
        en_a = 1'b0; en_b = 1'b0; hsync = 1'b0; vsync = 1'b0;
        if (e) model_beat(hs, vs, dm);
        else exp_v = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic frame_start();
        vcount = 0; fv_seen = 1'b0;
    endtask

    initial begin
        logic [71:0] ft;
        int ftaps [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        @(posedge clk);
        #1;
        do_reset();

        // Clean 8x8 ramp frame
        frame_start();
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                step(1'b1, 1'b0, (x == 0 && y == 0), y * 8 + x, "ramp");
        checks++;
        assert (vcount == (MASK ? 64 : 36)) else begin
            errors++; $error("FAIL valid_count: got %0d want %0d", vcount, MASK ? 64 : 36);
        end
        for (int i = 0; i < 9; i++) ft[i*8 +: 8] = MASK ? 8'd0 : 8'(ftaps[i]);
        checks++;
        assert (fx === (MASK ? 16'd0 : 16'd2) && fy === (MASK ? 16'd0 : 16'd2) && fw[71:0] === ft) else begin
            errors++; $error("FAIL first_valid: got (%0d,%0d) %h want (%0d,%0d) %h",
                             fx, fy, fw[71:0], MASK ? 0 : 2, MASK ? 0 : 2, ft);
        end

        // Same frame with en toggling: outputs hold in gaps
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                step(1'b1, 1'b0, (x == 0 && y == 0), y * 8 + x, "toggle_on");
                step(1'b0, 1'b0, 1'b0, 0, "toggle_off");
            end

        // Short line: hsync after column 5 of row 3
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                if (y == 3 && x > 5) continue;
                step(1'b1, (y == 4 && x == 0), (x == 0 && y == 0), y * 8 + x, "short_line");
                if (y == 4 && x == 0) begin
                    checks++;
                    assert (xa === 16'd0 && ya === 16'd4) else begin
                        errors++; $error("FAIL hsync_pos: got (%0d,%0d) want (0,4)", xa, ya);
                    end
                end
            end

        // Random pixels, gaps, occasional hsync/vsync
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0, int'($urandom_range(0, 255)), "random");

        // Mid-frame reset, then a frame without vsync
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, (i == 0), i * 3, "pre_reset");
        do_reset();
        frame_start();
        for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1'b0, 200 - i, "post_reset");
        checks++;
        assert (fx === (MASK ? 16'd0 : 16'd2) && fy === (MASK ? 16'd0 : 16'd2)) else begin
            errors++; $error("FAIL reset_first_valid: got (%0d,%0d) want (%0d,%0d)",
                             fx, fy, MASK ? 0 : 2, MASK ? 0 : 2);
        end

        // K=5, 10-bit, 16-wide instance
        sel = 1; K = 5; FW = 16; DW = 10;
        for (int i = 0; i < 16; i++) hist[i].delete();
        do_reset();
        frame_start();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                step(1'b1, 1'b0, (x == 0 && y == 0), y * 16 + x, "k5_ramp");
        checks++;
        assert (fx === (MASK ? 16'd0 : 16'd4) && fy === (MASK ? 16'd0 : 16'd4) &&
                fw[9:0] === 10'd0 && fw[249:240] === (MASK ? 10'd0 : 10'd68)) else begin
            errors++; $error("FAIL k5_first_valid: got (%0d,%0d) t0=%0d t24=%0d", fx, fy, fw[9:0], fw[249:240]);
        end
        checks++;
        assert (vcount == (MASK ? 256 : 144)) else begin
            errors++; $error("FAIL k5_valid_count: got %0d want %0d", vcount, MASK ? 256 : 144);
        end
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 199) == 0, int'($urandom_range(0, 1023)), "k5_random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
